// File: rtl/apu_pkg.sv
// Shared APU definitions: DMC reader state encoding, register view and address constants.
package apu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    FULL = 2'd2
  } dmc_state_t;

  typedef struct packed {
    logic [7:0] sample_addr_data;
    logic [7:0] sample_len_data;
    logic       loop;
    logic       irq_en;
  } dmc_t;

  localparam logic [15:0] DMC_ADDR_BASE = 16'hC000;
  localparam logic [15:0] DMC_WRAP_ADDR = 16'h8000;

  // regs[0..3] map to $4010..$4013; $4011 (direct load) is not used here.
  function automatic dmc_t dmc_extract(input logic [3:0][7:0] regs);
    dmc_t d;
    d.irq_en           = regs[0][7];
    d.loop             = regs[0][6];
    d.sample_addr_data = regs[2];
    d.sample_len_data  = regs[3];
    return d;
  endfunction

endpackage

// File: rtl/dmc_memory_reader.sv
// DMC memory reader: sample address/length sequencing, DMA byte requests and one-byte buffer.
// Optional IRQ flag is built only when APU_DMC_IRQ_EN is defined; otherwise irq is tied low.
//
// state | meaning
// IDLE  | buffer empty, waiting for cpu_clk_en with bytes remaining
// REQ   | read request outstanding on the DMA arbiter
// FULL  | sample buffer holds a byte until buf_take
module dmc_memory_reader (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_clk_en,
  input  logic [7:0]  sample_addr_data,
  input  logic [7:0]  sample_len_data,
  input  logic        loop,
  input  logic        irq_en,
  input  logic        enable_load,
  input  logic        enable,
  output logic        mem_req,
  output logic [15:0] mem_addr,
  input  logic        mem_ack,
  input  logic [7:0]  mem_data,
  output logic        buf_valid,
  output logic [7:0]  buf_data,
  input  logic        buf_take,
  output logic        active,
  output logic        irq
);
  import apu_pkg::*;

  dmc_state_t  state_q, state_d;
  logic [15:0] cur_addr_q, cur_addr_d;
  logic [11:0] bytes_q, bytes_d;
  logic [7:0]  buf_data_q, buf_data_d;
  logic        loop_q, loop_d;
  logic        done;

  dmc_t        cfg;
  logic [15:0] start_addr;
  logic [11:0] start_len;

  assign cfg        = dmc_extract({sample_len_data, sample_addr_data, 8'h00, irq_en, loop, 6'b0});
  assign start_addr = DMC_ADDR_BASE + {2'b00, cfg.sample_addr_data, 6'b000000};
  assign start_len  = {cfg.sample_len_data, 4'b0000} + 12'd1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cur_addr_q <= DMC_ADDR_BASE;
      bytes_q    <= '0;
      buf_data_q <= '0;
      loop_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cur_addr_q <= cur_addr_d;
      bytes_q    <= bytes_d;
      buf_data_q <= buf_data_d;
      loop_q     <= loop_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cur_addr_d = cur_addr_q;
    bytes_d    = bytes_q;
    buf_data_d = buf_data_q;
    loop_d     = loop_q;
    done       = 1'b0;
    case (state_q)
      IDLE: if (cpu_clk_en && bytes_q != 12'd0) state_d = REQ;
      REQ: begin
        if (mem_ack) begin
          state_d    = FULL;
          buf_data_d = mem_data;
          cur_addr_d = (cur_addr_q == 16'hFFFF) ? DMC_WRAP_ADDR : cur_addr_q + 16'd1;
          // A request left over from a disable completes without touching the count.
          if (bytes_q != 12'd0) begin
            bytes_d = bytes_q - 12'd1;
            if (bytes_q == 12'd1) begin
              done = 1'b1;
              if (loop_q) begin
                cur_addr_d = start_addr;
                bytes_d    = start_len;
                loop_d     = cfg.loop;
              end
            end
          end
        end
      end
      FULL: if (buf_take) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (enable_load) begin
      if (!enable) begin
        bytes_d = '0;
      end else if (bytes_q == 12'd0) begin
        cur_addr_d = start_addr;
        bytes_d    = start_len;
        loop_d     = cfg.loop;
      end
    end
  end

  assign mem_req   = (state_q == REQ);
  assign mem_addr  = cur_addr_q;
  assign buf_valid = (state_q == FULL);
  assign buf_data  = buf_data_q;
  assign active    = (bytes_q != 12'd0);

`ifdef APU_DMC_IRQ_EN
  logic irq_q, irq_d;
  logic irq_set;

  assign irq_set = done && !loop_q && cfg.irq_en;

  always_comb begin
    irq_d = irq_q;
    if (irq_set)                         irq_d = 1'b1;
    else if (enable_load || !cfg.irq_en) irq_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) irq_q <= 1'b0;
    else     irq_q <= irq_d;
  end

  assign irq = irq_q;
`else
  logic unused_irq;
  assign unused_irq = cfg.irq_en ^ done;
  assign irq        = 1'b0;
`endif

endmodule
